// File: rtl/riscv_v_mask_packer.sv
// Vector mask packer: reduces per-byte adder flags to one bit per element
// and packs them into a mask register image for writeback.
module riscv_v_mask_packer #(
    parameter int DATA_BYTES = 16,
    parameter int MAX_BEATS  = 8,
    parameter int MASK_WIDTH = DATA_BYTES * MAX_BEATS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [3:0]            osize,
    input  logic [2:0]            mask_op,
    input  logic [DATA_BYTES-1:0] cf,
    input  logic [DATA_BYTES-1:0] of,
    input  logic [DATA_BYTES-1:0] zf,
    input  logic [DATA_BYTES-1:0] lt,
    input  logic [DATA_BYTES-1:0] byte_valid,
    input  logic [MASK_WIDTH-1:0] mask_undist,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MASK_WIDTH-1:0] out_mask,
    output logic [7:0]            out_nelem,
    output logic                  out_err
);

    localparam int PW = $clog2(MASK_WIDTH + 1);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam int BW = $clog2(DATA_BYTES);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                state, state_nxt;
    logic [MASK_WIDTH-1:0] mask_r, mask_nxt, base_mask, wr_sel, wr_bits;
    logic [PW-1:0]         ptr, ptr_nxt, base_ptr, nelem_beat;
    logic [CW-1:0]         cnt, cnt_nxt, base_cnt;
    logic [1:0]            k_r, k_in, k_eff;
    logic [2:0]            op_r, op_eff;
    logic                  err_r;
    logic                  accept, start, load, ovf;
    logic [DATA_BYTES-1:0] ebits, evalid;
    logic [BW-1:0]         b;

    function automatic logic flag_fn(input logic [2:0] op,
                                     input logic c, input logic o,
                                     input logic z, input logic l);
        logic r;
        unique case (op)
            3'd0: r = c;
            3'd1: r = o;
            3'd2: r = z;
            3'd3: r = ~z;
            3'd4: r = l;
            3'd5: r = l | z;
            3'd6: r = ~l & ~z;
            3'd7: r = ~l;
        endcase
        return r;
    endfunction

    // Non-one-hot sizes fall back to 8-bit elements.
    always_comb begin
        case (osize)
            4'b0010: k_in = 2'd1;
            4'b0100: k_in = 2'd2;
            4'b1000: k_in = 2'd3;
            default: k_in = 2'd0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign start  = accept && in_first;
    assign load   = start || (accept && state == ACCUM);
    assign k_eff  = start ? k_in : k_r;
    assign op_eff = start ? mask_op : op_r;

    // Each element reads the flags of its most significant byte.
    always_comb begin
        ebits  = '0;
        evalid = '0;
        b      = '0;
        for (int j = 0; j < DATA_BYTES; j++) begin
            if (j < (DATA_BYTES >> k_eff)) begin
                b         = BW'(((j + 1) << k_eff) - 1);
                ebits[j]  = flag_fn(op_eff, cf[b], of[b], zf[b], lt[b]);
                evalid[j] = byte_valid[b];
            end
        end
    end

    always_comb begin
        base_mask  = start ? mask_undist : mask_r;
        base_ptr   = start ? '0 : ptr;
        base_cnt   = start ? '0 : cnt;
        nelem_beat = PW'(DATA_BYTES >> k_eff);
        wr_sel     = MASK_WIDTH'(evalid) << base_ptr;
        wr_bits    = MASK_WIDTH'(ebits & evalid) << base_ptr;
        mask_nxt   = (base_mask & ~wr_sel) | wr_bits;
        ptr_nxt    = base_ptr + nelem_beat;
        cnt_nxt    = base_cnt + 1'b1;
        ovf        = (cnt_nxt == CW'(MAX_BEATS)) && !in_last;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, ACCUM: if (load) state_nxt = (in_last || ovf) ? OUT : ACCUM;
            OUT:         if (out_ready) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != OUT);
        out_valid = (state == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r <= '0;
            ptr    <= '0;
            cnt    <= '0;
            k_r    <= '0;
            op_r   <= '0;
            err_r  <= 1'b0;
        end else if (load) begin
            mask_r <= mask_nxt;
            ptr    <= ptr_nxt;
            cnt    <= cnt_nxt;
            err_r  <= ovf;
            if (start) begin
                k_r  <= k_in;
                op_r <= mask_op;
            end
        end else if (state == OUT && out_ready) begin
            ptr   <= '0;
            cnt   <= '0;
            err_r <= 1'b0;
        end
    end

    assign out_mask  = mask_r;
    assign out_nelem = 8'(ptr);
    assign out_err   = err_r;

endmodule

// File: tb/tb_riscv_v_mask_packer.sv
// Directed bench for riscv_v_mask_packer: table of single-beat ops plus
// hand-written multi-beat, backpressure, overflow, restart and reset cases.
module tb_riscv_v_mask_packer;

    localparam logic [2:0] CF = 3'd0, OF = 3'd1, EQ = 3'd2, NE = 3'd3;
    localparam logic [2:0] LT = 3'd4, LE = 3'd5, GT = 3'd6, GE = 3'd7;
    localparam logic [3:0] S8 = 4'b0001, S16 = 4'b0010;
    localparam logic [3:0] S32 = 4'b0100, S64 = 4'b1000;
    localparam logic [127:0] ONES = {128{1'b1}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_first, in_last;
    logic [3:0]   osize;
    logic [2:0]   mask_op;
    logic [15:0]  cf, of, zf, lt, byte_valid;
    logic [127:0] mask_undist;
    logic         out_valid, out_ready, out_err;
    logic [127:0] out_mask;
    logic [7:0]   out_nelem;

    int n_cmp = 0;
    int n_bad = 0;

    riscv_v_mask_packer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last),
        .osize(osize), .mask_op(mask_op),
        .cf(cf), .of(of), .zf(zf), .lt(lt),
        .byte_valid(byte_valid), .mask_undist(mask_undist),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mask(out_mask), .out_nelem(out_nelem), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [3:0]   os;
        logic [15:0]  c, o, z, l, v;
        logic [127:0] u, emask;
        logic [7:0]   enel;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic f, input logic l, input logic [2:0] op,
                        input logic [3:0] os, input logic [15:0] c,
                        input logic [15:0] o, input logic [15:0] z,
                        input logic [15:0] t, input logic [15:0] v,
                        input logic [127:0] u);
        in_first = f; in_last = l; mask_op = op; osize = os;
        cf = c; of = o; zf = z; lt = t; byte_valid = v; mask_undist = u;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_in_ready_after"}, 128'(in_ready), 128'd1);
        chk({name, "_out_valid_after"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        vecs[0] = '{EQ, S8, 16'h0, 16'h0, 16'h00FF, 16'h0, 16'hFFFF,
                    128'h0, 128'h00FF, 8'd16};
        vecs[1] = '{CF, S16, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h00FF,
                    ONES, ONES, 8'd8};
        vecs[2] = '{CF, S16, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h00FF,
                    128'h0, 128'h0F, 8'd8};
        vecs[3] = '{NE, S8, 16'h0, 16'h0, 16'h00FF, 16'h0, 16'hFFFF,
                    128'h0, 128'hFF00, 8'd16};
        vecs[4] = '{OF, S64, 16'h0, 16'h0080, 16'h0, 16'h0, 16'hFFFF,
                    128'hF0, 128'hF1, 8'd2};
        vecs[5] = '{LE, S32, 16'h0, 16'h0, 16'h0800, 16'h0008, 16'hFFFF,
                    128'h0, 128'h5, 8'd4};
        vecs[6] = '{GT, S32, 16'h0, 16'h0, 16'h0800, 16'h0008, 16'hFFFF,
                    128'h0, 128'hA, 8'd4};
        vecs[7] = '{GE, S16, 16'h0, 16'h0, 16'h0, 16'hAAAA, 16'hFFFF,
                    ONES, ~128'hFF, 8'd8};
        vecs[8] = '{LT, 4'b0011, 16'h0, 16'h0, 16'h0, 16'h1234, 16'h0F0F,
                    128'h0, 128'h0204, 8'd16};

        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        osize = S8; mask_op = EQ; cf = '0; of = '0; zf = '0; lt = '0;
        byte_valid = '0; mask_undist = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_mask", out_mask, 128'd0);
        chk("rst_out_nelem", 128'(out_nelem), 128'd0);
        chk("rst_out_err", 128'(out_err), 128'd0);

        for (int i = 0; i < 9; i++) begin
            beat(1'b1, 1'b1, vecs[i].op, vecs[i].os, vecs[i].c, vecs[i].o,
                 vecs[i].z, vecs[i].l, vecs[i].v, vecs[i].u);
            chk($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'd1);
            chk($sformatf("v%0d_mask", i), out_mask, vecs[i].emask);
            chk($sformatf("v%0d_nelem", i), 128'(out_nelem),
                128'(vecs[i].enel));
            chk($sformatf("v%0d_err", i), 128'(out_err), 128'd0);
            handshake($sformatf("v%0d", i));
        end

        // Two-beat LT on 32-bit elements over a non-zero old mask.
        beat(1'b1, 1'b0, LT, S32, 16'h0, 16'h0, 16'h0, 16'h8008, 16'hFFFF,
             {120'hA5A5_5A5A_0123_4567_89AB_CDEF_FEDC_BA, 8'hFF});
        chk("lt2_mid_out_valid", 128'(out_valid), 128'd0);
        beat(1'b0, 1'b1, LT, S8, 16'h0, 16'h0, 16'h0, 16'h0080, 16'hFFFF,
             ONES);
        chk("lt2_out_valid", 128'(out_valid), 128'd1);
        chk("lt2_mask", out_mask,
            {120'hA5A5_5A5A_0123_4567_89AB_CDEF_FEDC_BA, 8'h29});
        chk("lt2_nelem", 128'(out_nelem), 128'd8);
        handshake("lt2");

        // Backpressure with a competing first beat presented.
        beat(1'b1, 1'b1, EQ, S8, 16'h0, 16'h0, 16'h00FF, 16'h0, 16'hFFFF,
             128'h0);
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; zf = 16'hFFFF;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp%0d_mask", c), out_mask, 128'h00FF);
            chk($sformatf("bp%0d_in_ready", c), 128'(in_ready), 128'd0);
            chk($sformatf("bp%0d_out_valid", c), 128'(out_valid), 128'd1);
        end
        in_valid = 1'b0;
        handshake("bp");
        tick();
        chk("bp_no_extra_op", 128'(out_valid), 128'd0);

        // Eight beats without in_last overflow the beat counter.
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("ovf%0d_in_ready", c), 128'(in_ready), 128'd1);
            beat(c == 0, 1'b0, EQ, S8, 16'h0, 16'h0, 16'hFFFF, 16'h0,
                 16'hFFFF, 128'h0);
        end
        chk("ovf_out_valid", 128'(out_valid), 128'd1);
        chk("ovf_err", 128'(out_err), 128'd1);
        chk("ovf_nelem", 128'(out_nelem), 128'd128);
        chk("ovf_mask", out_mask, ONES);
        handshake("ovf");
        chk("ovf_err_cleared", 128'(out_err), 128'd0);
        chk("ovf_nelem_cleared", 128'(out_nelem), 128'd0);

        // Beat without in_first in IDLE is dropped.
        beat(1'b0, 1'b1, EQ, S8, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF,
             128'h0);
        chk("drop_out_valid", 128'(out_valid), 128'd0);
        chk("drop_nelem", 128'(out_nelem), 128'd0);

        // in_first during ACCUM abandons the partial op.
        beat(1'b1, 1'b0, EQ, S8, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF,
             128'h0);
        chk("rs_mid_out_valid", 128'(out_valid), 128'd0);
        beat(1'b1, 1'b1, NE, S8, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF,
             128'h0);
        chk("rs_out_valid", 128'(out_valid), 128'd1);
        chk("rs_mask", out_mask, 128'h0);
        chk("rs_nelem", 128'(out_nelem), 128'd16);
        handshake("rs");

        // Reset in the middle of an op.
        beat(1'b1, 1'b0, EQ, S8, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF,
             ONES);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_out_valid", 128'(out_valid), 128'd0);
        chk("mr_in_ready", 128'(in_ready), 128'd1);
        chk("mr_mask", out_mask, 128'h0);
        chk("mr_nelem", 128'(out_nelem), 128'd0);
        chk("mr_err", 128'(out_err), 128'd0);
        tick();
        chk("mr_stays_idle", 128'(out_valid), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_v_mask_packer.md
Name: riscv_v_mask_packer

Overview:
- Downstream of the vector adder. Consumes the adder's per-byte carry, overflow, zero and less-than flags, one beat per register of a register group.
- Reduces each beat to one mask bit per element and packs the bits contiguously into a mask register image.
- Hands the packed mask to the vector register file writeback over a valid/ready handshake.
- Implements the mask-producing ops: vmadc/vmsbc (carry), vmseq/vmsne/vmslt/vmsle/vmsgt/vmsge, and the overflow mask.

Parameters:
- DATA_BYTES, 16, bytes per beat (matches vector datapath byte count).
- MAX_BEATS, 8, maximum beats per operation (LMUL=8).
- MASK_WIDTH, DATA_BYTES*MAX_BEATS, packed mask width in bits.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  flag beat valid.
- in_ready  output  1  packer accepts a beat.
- in_first  input  1  first beat of an operation.
- in_last  input  1  last beat of an operation.
- osize  input  4  one-hot element size: [0]=8b, [1]=16b, [2]=32b, [3]=64b; sampled on the first beat.
- mask_op  input  3  0=CF, 1=OF, 2=EQ, 3=NE, 4=LT, 5=LE, 6=GT, 7=GE; sampled on the first beat.
- cf, of, zf, lt  input  DATA_BYTES each  per-byte adder flags.
- byte_valid  input  DATA_BYTES  per-byte active (body and mask-enabled).
- mask_undist  input  MASK_WIDTH  old destination mask; sampled on the first beat.
- out_valid  output  1  packed mask valid.
- out_ready  input  1  writeback accepts.
- out_mask  output  MASK_WIDTH  packed mask.
- out_nelem  output  8  number of element bits written.
- out_err  output  1  beat overflow: MAX_BEATS beats accepted without in_last.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_mask=0, out_nelem=0, out_err=0, internal bit pointer=0, beat counter=0.
- States: IDLE, ACCUM, OUT.
- Accept: a beat is accepted when in_valid && in_ready. in_ready=1 in IDLE and ACCUM, 0 in OUT.
- IDLE:
  - An accepted beat without in_first is dropped; state stays IDLE.
  - An accepted beat with in_first latches osize, mask_op and mask_undist into the mask register, sets pointer=0 and beat counter=0, then processes the beat.
  - A first beat that also has in_last goes directly to OUT.
- ACCUM:
  - Accepted beats are processed.
  - A beat with in_last goes to OUT.
  - A beat with in_first abandons the current op and restarts as in IDLE; no output is produced for the abandoned op.
- Beat processing, with k = log2 of element bytes:
  - Elements per beat E = DATA_BYTES >> k.
  - Element j takes its flags from byte b = (j+1)*2^k - 1, its most significant byte.
  - Flag function: CF=cf[b]; OF=of[b]; EQ=zf[b]; NE=~zf[b]; LT=lt[b]; LE=lt[b]|zf[b]; GT=~lt[b]&~zf[b]; GE=~lt[b].
  - If byte_valid[b]=1, mask bit pointer+j gets the function value; otherwise it keeps its mask_undist value.
  - Then pointer += E and beat counter += 1. Bits at or above the final pointer keep mask_undist (tail undisturbed).
- Overflow: when the beat counter reaches MAX_BEATS without in_last, go to OUT with out_err=1.
- OUT:
  - out_valid=1.
  - out_mask and out_nelem (= final pointer) stay stable until out_ready.
  - On out_valid && out_ready: go to IDLE, out_valid=0, out_err=0, pointer=0.
- Latency: out_valid asserts the cycle after the last beat is accepted, with no bubble. out_ready may stay high continuously, giving one op per (beats+1) cycles.
- Pointer: never exceeds MASK_WIDTH; there is no wrap, because MAX_BEATS*DATA_BYTES bounds it.
- Reset mid-operation: returns to IDLE and discards the partial mask; no out_valid is produced.
- Invalid inputs: if osize is not one-hot on the first beat, treat it as 8b.

Test Plan:
- EQ, 8b, 1 beat (first+last), zf=16'h00FF, byte_valid=all ones, mask_undist=0 -> next cycle out_valid=1, out_mask[15:0]=16'h00FF, out_nelem=16.
- LT, 32b, 2 beats, lt bytes 3 and 15 set in beat 0 and byte 7 in beat 1 -> out_mask[7:0]=8'b0010_1001, out_nelem=8, upper bits equal mask_undist.
- CF, 16b, 1 beat, cf=all ones, byte_valid=16'h00FF, mask_undist=all ones -> out_mask[7:0]=8'hFF. Bits 4-7 keep 1 as inactive elements.
- Backpressure: out_ready=0 for 5 cycles after completion -> out_mask stable, in_ready=0, a beat presented in that window is not accepted; on out_ready=1 the op completes and in_ready=1 the next cycle.
- Overflow: 8 beats without in_last -> OUT with out_err=1, out_nelem=128 (8b).
- Restart and reset: in_first during ACCUM restarts with pointer=0 and no output for the old op. rst asserted mid-op -> IDLE, out_valid=0, all outputs zero.
